// File: rtl/wb_pkg.sv
// Shared constants, entry type and free-slot helper
// for the register writeback queue.
package wb_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // The head always pops while occupied,
  // so its slot is usable in the same cycle.
  function automatic int unsigned wb_space(
    input int unsigned cnt,
    input int unsigned depth
  );
    return depth - cnt + ((cnt != 0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Writeback storage: circular buffer, two ordered
// write ports (wr0 older), auto-pop of head, age view.
// Ports: clk, rst_n, wr0_*/wr1_* enqueue, cnt,
// ord_vld/ord_dest/ord_data (index 0 = head/oldest).
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr0_en,
  input  logic [ADDR_W-1:0]             wr0_dest,
  input  logic [DATA_W-1:0]             wr0_data,
  input  logic                          wr1_en,
  input  logic [ADDR_W-1:0]             wr1_dest,
  input  logic [DATA_W-1:0]             wr1_data,
  output logic [$clog2(DEPTH):0]        cnt,
  output logic [DEPTH-1:0]              ord_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ord_dest,
  output logic [DEPTH-1:0][DATA_W-1:0]  ord_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic          pop;
  logic [PW-1:0] slot1;
  logic [PW-1:0] idx;

  always_comb begin
    pop    = (cnt_q != '0);
    dest_d = dest_q;
    data_d = data_q;
    slot1  = tail_q + PW'(wr0_en);
    if (wr0_en) begin
      dest_d[tail_q] = wr0_dest;
      data_d[tail_q] = wr0_data;
    end
    if (wr1_en) begin
      dest_d[slot1] = wr1_dest;
      data_d[slot1] = wr1_data;
    end
    head_d = head_q + PW'(pop);
    tail_d = slot1 + PW'(wr1_en);
    cnt_d  = cnt_q - CW'(pop)
           + CW'(wr0_en) + CW'(wr1_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
    dest_q <= dest_d;
    data_q <= data_d;
  end

  always_comb begin
    idx      = '0;
    ord_vld  = '0;
    ord_dest = '0;
    ord_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx         = head_q + PW'(i);
      ord_vld[i]  = (CW'(i) < cnt_q);
      ord_dest[i] = dest_q[idx];
      ord_data[i] = data_q[idx];
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Register writeback queue: ALU/mem handshakes, XZR drop,
// one retire per cycle, pending flags. Macro WB_BYPASS_EN
// adds fwd_data_1/fwd_data_2 (youngest matching value).
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_dest,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      reg_write_dest,
  output logic [DATA_W-1:0]      reg_write_data,
  input  logic [ADDR_W-1:0]      query_addr_1,
  input  logic [ADDR_W-1:0]      query_addr_2,
  output logic                   pending_1,
  output logic                   pending_2,
  output logic [$clog2(DEPTH):0] count
`ifdef WB_BYPASS_EN
  ,
  output logic [DATA_W-1:0]      fwd_data_1,
  output logic [DATA_W-1:0]      fwd_data_2
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] XZR =
    ADDR_W'(ZERO_REG);

  logic [CW-1:0]                cnt;
  logic [DEPTH-1:0]             ord_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ord_dest;
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;
  int unsigned                  space;
  logic                         mem_en;
  logic                         alu_en;
  logic                         hit_1;
  logic                         hit_2;

  assign space = wb_space(32'(cnt), 32'(DEPTH));

  assign mem_ready = rst_n && (space >= 32'd1);
  assign alu_ready = rst_n &&
    ((space >= 32'd2) ||
     ((space >= 32'd1) && !mem_valid));

  // XZR requests complete the handshake but never enqueue.
  assign mem_en = mem_valid && mem_ready &&
                  (mem_dest != XZR);
  assign alu_en = alu_valid && alu_ready &&
                  (alu_dest != XZR);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (mem_en),
    .wr0_dest (mem_dest),
    .wr0_data (mem_data),
    .wr1_en   (alu_en),
    .wr1_dest (alu_dest),
    .wr1_data (alu_data),
    .cnt      (cnt),
    .ord_vld  (ord_vld),
    .ord_dest (ord_dest),
    .ord_data (ord_data)
  );

  // Gated by rst_n so nothing retires on a reset edge.
  assign reg_write      = rst_n && ord_vld[0];
  assign reg_write_dest = reg_write ? ord_dest[0] : '0;
  assign reg_write_data = reg_write ? ord_data[0] : '0;
  assign count          = rst_n ? cnt : '0;

  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && ord_dest[i] == query_addr_1)
        hit_1 = 1'b1;
      if (ord_vld[i] && ord_dest[i] == query_addr_2)
        hit_2 = 1'b1;
    end
  end

  assign pending_1 = rst_n && hit_1 &&
                     (query_addr_1 != XZR);
  assign pending_2 = rst_n && hit_2 &&
                     (query_addr_2 != XZR);

`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] fwd_1;
  logic [DATA_W-1:0] fwd_2;

  // Ascending age scan: later (younger) hits win.
  always_comb begin
    fwd_1 = '0;
    fwd_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && ord_dest[i] == query_addr_1)
        fwd_1 = ord_data[i];
      if (ord_vld[i] && ord_dest[i] == query_addr_2)
        fwd_2 = ord_data[i];
    end
  end

  assign fwd_data_1 = pending_1 ? fwd_1 : '0;
  assign fwd_data_2 = pending_2 ? fwd_2 : '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Writeback buffer that drives the register file write port. Accepts results from the ALU and from the data memory over valid/ready handshakes, queues them in program order, and retires one entry per cycle as a single write on `reg_write`/`reg_write_dest`/`reg_write_data`. Per-register pending flags let the hazard logic stall readers of registers with writes still in flight.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2
- `DATA_W`, 64: result width
- `ADDR_W`, 5: register address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle if `alu_valid`
- `alu_dest`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_valid` / `mem_ready` / `mem_dest` / `mem_data`: same as the ALU port, for load data
- `reg_write`  out  1  write strobe to register file
- `reg_write_dest`  out  ADDR_W  write address
- `reg_write_data`  out  DATA_W  write data
- `query_addr_1`, `query_addr_2`  in  ADDR_W  read addresses under hazard check
- `pending_1`, `pending_2`  out  1  queued write exists for the queried register
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer: head pointer, tail pointer, and count; each entry holds {dest, data}.
- Drain: when count>0, head is presented combinationally: `reg_write`=1, dest and data from head. Head pops at the same clock edge at which the register file samples it. Exactly one pop per cycle; no backpressure from the register file.
- Free slots this cycle: `space` = DEPTH − count + (count≠0). A pop frees its slot in the same cycle.
- `mem_ready` = (space≥1). `alu_ready` = (space≥2) or (space≥1 and not `mem_valid`). Both are functions of count and `mem_valid` only, never of `alu_valid`.
- Both ports fire in the same cycle: the mem entry enqueues first (older), the ALU entry second.
- A request to register 31 (XZR) is handshaken normally and discarded. It does not enqueue, does not consume space, and never asserts `pending`. The ready equations still use the actual space.
- `pending_k`: OR over valid entries of (dest == `query_addr_k`), including the head being written this cycle. Requests enqueuing this cycle are excluded. `query_addr_k`=31 always gives 0.
- No entry ever overwrites another. Pointers wrap modulo DEPTH.

## Timing
- Reset, sampled on a rising edge with `rst_n`=0: count=0, head=tail=0, and entry contents are don't-care. Reset takes priority over simultaneous enqueue and pop.
- Outputs while `rst_n`=0 and in the cycle after reset: `reg_write`=0, `reg_write_dest`=0, `reg_write_data`=0, `pending_*`=0, `count`=0. Both readies are forced 0 while `rst_n`=0.
- Latency: a request accepted at edge N, into an empty queue, appears on `reg_write` during cycle N→N+1. The register file commits it at edge N+1.
- Sustained throughput: one write per cycle. With both ports firing every cycle, the queue fills and the ALU port is throttled.
- Full queue (count=DEPTH): space=1, so a mem request is still accepted alongside the pop.
- If reset is asserted mid-drain, queued writes are lost. No partial write is emitted after the reset edge.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `fwd_data_1`, `fwd_data_2` (DATA_W). Each carries the data of the youngest valid entry matching `query_addr_k`, or 0 if `pending_k`=0. Readers can then consume in-flight values instead of stalling.
- `WB_BYPASS_EN` undefined: these ports and the youngest-match priority logic are absent. `pending_k` behaviour is identical in both builds.

## Structure
- Package `wb_pkg`:
  - constants `DATA_W`, `ADDR_W`, `ZERO_REG`=31
  - typedef `wb_entry_t` {dest, data}
  - function computing `space` from count
- Sub-module `wb_fifo`: storage, pointers, and count; two ordered write ports, one pop. The top level holds the handshake, XZR filtering, and hazard match/forward logic.

## Test plan
- Single ALU write of dest 3, data 0xDEAD_BEEF into an empty queue → `reg_write`=1 with dest 3, data 0xDEADBEEF for exactly one cycle the cycle after acceptance; `pending_1`=1 for `query_addr_1`=3 during that cycle only.
- Both ports valid every cycle for 10 cycles (mem dest 1..10, ALU dest 11..20) → writes emerge in order mem1, alu11, mem2, …; `alu_ready` drops once count reaches DEPTH; no entry is lost or duplicated.
- Full queue, `mem_valid` and `alu_valid` asserted → `mem_ready`=1, `alu_ready`=0, count stays DEPTH.
- Request with dest 31, data 0x1234 → handshake completes, `reg_write` stays 0, count unchanged, `pending`=0 for query 31.
- Two queued writes to dest 5 (0xA then 0xB); with `WB_BYPASS_EN` and `query_addr_2`=5 → `fwd_data_2`=0xB until the 0xB entry drains, then `pending_2`=0.
- Three entries queued, `rst_n`=0 for one edge → next cycle `reg_write`=0, `count`=0, readies 1; no queued data is written.
